// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8910 bus sequencer.
//   ay_cmd_e   : PSG bus commands, encoded as {bdir, bc1} (BC2 tied high)
//   ay_state_e : sequencer phases IDLE -> ADDR -> GAP1 -> XFER -> GAP2
//   AY_T_*_DEF : default phase lengths in clock cycles
//   ay_max3    : helper used to size the phase timer
package ay_pkg;

  typedef enum logic [1:0] {
    CMD_INACT = 2'b00,
    CMD_RDPSG = 2'b01,
    CMD_WRPSG = 2'b10,
    CMD_LADDR = 2'b11
  } ay_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP1,
    ST_XFER,
    ST_GAP2
  } ay_state_e;

  localparam int unsigned AY_T_ADDR_DEF = 4;
  localparam int unsigned AY_T_XFER_DEF = 4;
  localparam int unsigned AY_T_GAP_DEF  = 2;

  function automatic int unsigned ay_max3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// Loadable down-counter timing one sequencer phase.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset (count cleared)
//   load     : reload count with load_val this cycle
//   load_val : phase length in cycles (>= 1)
//   done     : high while the final cycle of the phase is in progress
module ay_phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count parks at zero between phases so done stays low while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/ay_bus_sequencer.sv
// AY-3-8910 PSG register access sequencer (BDIR/BC1 command pins, BC2 high).
// A host read/write request is turned into LADDR, INACT gap, WRPSG/RDPSG,
// INACT gap, with each phase length set by T_ADDR / T_XFER / T_GAP.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_write, req_addr, req_data : request fields, captured at acceptance
//   rsp_valid / rsp_data  : one-cycle read-data pulse, data held until next read
//   busy                  : high whenever not IDLE
//   ay_bdir, ay_bc1       : PSG command pins
//   ay_da_out, ay_da_oe   : DA bus drive value and enable
//   ay_da_in              : DA bus sampled value
//
// Build option: define AY_READ_EN to build the RDPSG read path. Without it
// a read request causes no bus activity and answers 8'hFF one cycle after
// acceptance; ay_da_in is then unused.
module ay_bus_sequencer
  import ay_pkg::*;
#(
  parameter int unsigned T_ADDR = AY_T_ADDR_DEF,
  parameter int unsigned T_XFER = AY_T_XFER_DEF,
  parameter int unsigned T_GAP  = AY_T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ay_bdir,
  output logic       ay_bc1,
  output logic [7:0] ay_da_out,
  output logic       ay_da_oe,
  input  logic [7:0] ay_da_in
);

  // Wide enough to hold the longest phase length itself.
  localparam int unsigned TW = $clog2(ay_max3(T_ADDR, T_XFER, T_GAP) + 1);

  ay_state_e   state;
  ay_cmd_e     cmd_q;
  logic        op_write;
  logic [3:0]  op_addr;
  logic [7:0]  op_data;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          accept;

  assign accept = req_valid && req_ready;
  assign {ay_bdir, ay_bc1} = cmd_q;

`ifndef AY_READ_EN
  logic unused_da_in;
  assign unused_da_in = ^ay_da_in;
`endif

  ay_phase_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer is reloaded with the next phase length on every state change.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(T_ADDR);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
`ifndef AY_READ_EN
          if (!req_write) tmr_val = TW'(1);
`endif
        end
      end
      ST_ADDR: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_GAP);
        end
      end
      ST_GAP1: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_XFER);
        end
      end
      ST_XFER: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_GAP);
        end
      end
      default: ;
    endcase
  end

  // Pin values are computed on the transition into each state so every
  // output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_INACT;
      ay_da_out <= '0;
      ay_da_oe  <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      op_write  <= 1'b0;
      op_addr   <= '0;
      op_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_write  <= req_write;
            op_addr   <= req_addr;
            op_data   <= req_data;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifndef AY_READ_EN
            if (!req_write) begin
              // Reads are not built: answer immediately, pins stay INACT,
              // and a one-cycle GAP2 stands in for the idle-ready delay.
              state     <= ST_GAP2;
              rsp_valid <= 1'b1;
              rsp_data  <= 8'hFF;
            end else
`endif
            begin
              state     <= ST_ADDR;
              cmd_q     <= CMD_LADDR;
              ay_da_out <= {4'b0000, req_addr};
              ay_da_oe  <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (tmr_done) begin
            state     <= ST_GAP1;
            cmd_q     <= CMD_INACT;
            ay_da_out <= '0;
            ay_da_oe  <= 1'b0;
          end
        end
        ST_GAP1: begin
          if (tmr_done) begin
            state <= ST_XFER;
            if (op_write) begin
              cmd_q     <= CMD_WRPSG;
              ay_da_out <= op_data;
              ay_da_oe  <= 1'b1;
            end else begin
`ifdef AY_READ_EN
              cmd_q <= CMD_RDPSG;
`endif
            end
          end
        end
        ST_XFER: begin
          if (tmr_done) begin
            state     <= ST_GAP2;
            cmd_q     <= CMD_INACT;
            ay_da_out <= '0;
            ay_da_oe  <= 1'b0;
`ifdef AY_READ_EN
            if (!op_write) begin
              rsp_data  <= ay_da_in;
              rsp_valid <= 1'b1;
            end
`endif
          end
        end
        ST_GAP2: begin
          if (tmr_done) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_q     <= CMD_INACT;
          ay_da_oe  <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
